// File: rtl/bridge_pkg.sv
// Shared encodings for the drawbridge plant emulator: boat/car sequencer states
// and the bit positions of the sticky fault register.
package bridge_pkg;

  typedef enum logic [2:0] {
    BOAT_IDLE,
    BOAT_APPROACH,
    BOAT_WAIT,
    BOAT_CROSS,
    BOAT_CLEAR
  } boat_state_e;

  typedef enum logic {
    CAR_IDLE,
    CAR_ON_DECK
  } car_state_e;

  localparam int FLT_CAR_DECK  = 0;
  localparam int FLT_BOAT_DECK = 1;
  localparam int FLT_NO_ALARM  = 2;
  localparam int NUM_FLT       = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bridge_deck_model.sv
// Deck position model: a free-running prescaler paces the deck one step per
// STEP_DIV cycles in the direction commanded by mt, saturating at both ends.
module bridge_deck_model #(
  parameter int DECK_TRAVEL = 8,
  parameter int STEP_DIV    = 4,
  parameter int POS_W       = $clog2(DECK_TRAVEL + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mt,
  output logic [POS_W-1:0] pos,
  output logic             at_top,
  output logic             at_bottom
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [POS_W-1:0] POS_TOP    = POS_W'(DECK_TRAVEL);

  logic [DIV_W-1:0] presc_q, presc_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             step;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    step    = (presc_q == PRESC_LAST);
    presc_d = step ? '0 : presc_q + 1'b1;
    pos_d   = pos_q;
    if (step) begin
      if (mt && (pos_q != POS_TOP)) begin
        pos_d = pos_q + 1'b1;
      end else if (!mt && (pos_q != '0)) begin
        pos_d = pos_q - 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      pos_q   <= '0;
    end else begin
      presc_q <= presc_d;
      pos_q   <= pos_d;
    end
  end

  assign pos       = pos_q;
  assign at_top    = (pos_q == POS_TOP);
  assign at_bottom = (pos_q == '0);

endmodule

// File: rtl/bridge_plant_model.sv
// Drawbridge plant emulator: turns the controller's MT/AL/TFL commands into
// sensor inputs S1..S6 and records unsafe plant situations as sticky faults.
module bridge_plant_model
  import bridge_pkg::*;
#(
  parameter int DECK_TRAVEL  = 8,
  parameter int STEP_DIV     = 4,
  parameter int APPROACH_CYC = 6,
  parameter int CROSS_CYC    = 5,
  parameter int CLEAR_CYC    = 3,
  parameter int CAR_CYC      = 4
) (
  input  logic                               Clock,
  input  logic                               Reset,
  input  logic                               MT,
  input  logic                               AL,
  input  logic                               TFL,
  input  logic                               boat_req,
  input  logic                               car_req,
  output logic                               S1,
  output logic                               S2,
  output logic                               S3,
  output logic                               S4,
  output logic                               S5,
  output logic                               S6,
  output logic [$clog2(DECK_TRAVEL+1)-1:0]   deck_pos,
  output logic [NUM_FLT-1:0]                 fault
);

  localparam int POS_W   = $clog2(DECK_TRAVEL + 1);
  localparam int MAX_CYC = max_int(max_int(APPROACH_CYC, CROSS_CYC), max_int(CLEAR_CYC, CAR_CYC));
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [POS_W-1:0] pos;
  logic             deck_up, deck_down;

  bridge_deck_model #(
    .DECK_TRAVEL(DECK_TRAVEL),
    .STEP_DIV   (STEP_DIV),
    .POS_W      (POS_W)
  ) u_deck (
    .clk      (Clock),
    .rst_n    (Reset),
    .mt       (MT),
    .pos      (pos),
    .at_top   (deck_up),
    .at_bottom(deck_down)
  );

  boat_state_e  boat_state_q, boat_state_d;
  logic [CNT_W-1:0] boat_cnt_q, boat_cnt_d;
  car_state_e   car_state_q, car_state_d;
  logic [CNT_W-1:0] car_cnt_q, car_cnt_d;
  logic [NUM_FLT-1:0] fault_q, fault_d, flt_now;

  // Each timed state loads (duration - 1) and leaves when the counter hits zero.
  always_comb begin
    boat_state_d = boat_state_q;
    boat_cnt_d   = boat_cnt_q;
    unique case (boat_state_q)
      BOAT_IDLE: begin
        if (boat_req) begin
          boat_state_d = BOAT_APPROACH;
          boat_cnt_d   = CNT_W'(APPROACH_CYC - 1);
        end
      end
      BOAT_APPROACH: begin
        if (boat_cnt_q == '0) boat_state_d = BOAT_WAIT;
        else                  boat_cnt_d   = boat_cnt_q - 1'b1;
      end
      BOAT_WAIT: begin
        if (deck_up) begin
          boat_state_d = BOAT_CROSS;
          boat_cnt_d   = CNT_W'(CROSS_CYC - 1);
        end
      end
      BOAT_CROSS: begin
        if (boat_cnt_q == '0) begin
          boat_state_d = BOAT_CLEAR;
          boat_cnt_d   = CNT_W'(CLEAR_CYC - 1);
        end else begin
          boat_cnt_d = boat_cnt_q - 1'b1;
        end
      end
      BOAT_CLEAR: begin
        if (boat_cnt_q == '0) boat_state_d = BOAT_IDLE;
        else                  boat_cnt_d   = boat_cnt_q - 1'b1;
      end
      default: boat_state_d = BOAT_IDLE;
    endcase
  end

  // A car may only enter on a green light with the deck fully down; once on,
  // it leaves on its own schedule regardless of what the deck does.
  always_comb begin
    car_state_d = car_state_q;
    car_cnt_d   = car_cnt_q;
    unique case (car_state_q)
      CAR_IDLE: begin
        if (car_req && !TFL && deck_down) begin
          car_state_d = CAR_ON_DECK;
          car_cnt_d   = CNT_W'(CAR_CYC - 1);
        end
      end
      CAR_ON_DECK: begin
        if (car_cnt_q == '0) car_state_d = CAR_IDLE;
        else                 car_cnt_d   = car_cnt_q - 1'b1;
      end
      default: car_state_d = CAR_IDLE;
    endcase
  end

  always_comb begin
    flt_now                = '0;
    flt_now[FLT_CAR_DECK]  = (car_state_q == CAR_ON_DECK) && !deck_down;
    flt_now[FLT_BOAT_DECK] = (boat_state_q == BOAT_CROSS) && !deck_up;
    flt_now[FLT_NO_ALARM]  = !deck_down && !AL;
    fault_d                = fault_q | flt_now;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      boat_state_q <= BOAT_IDLE;
      boat_cnt_q   <= '0;
      car_state_q  <= CAR_IDLE;
      car_cnt_q    <= '0;
      fault_q      <= '0;
    end else begin
      boat_state_q <= boat_state_d;
      boat_cnt_q   <= boat_cnt_d;
      car_state_q  <= car_state_d;
      car_cnt_q    <= car_cnt_d;
      fault_q      <= fault_d;
    end
  end

  assign S1       = (boat_state_q == BOAT_APPROACH);
  assign S2       = (boat_state_q == BOAT_WAIT) || (boat_state_q == BOAT_CROSS);
  assign S3       = (boat_state_q == BOAT_CLEAR);
  assign S4       = deck_up;
  assign S5       = deck_down;
  assign S6       = (car_state_q == CAR_ON_DECK);
  assign deck_pos = pos;
  assign fault    = fault_q;

endmodule
